// File: rtl/battle_turn_sequencer.sv
// Battle turn sequencer: runs one player-vs-boss encounter, owns both HP
// registers and paces every on-screen phase by video frame ticks.
//
// state          | meaning
// S_NO_BATTLE    | idle on the overworld
// S_INIT_BOSS    | load max HP, clear result (one cycle)
// S_START_BATTLE | intro on screen for SHOW_FRAMES ticks
// S_USER_TURN    | waiting for the player's move
// S_SHOW_USER    | player move on screen
// S_BOSS_TURN    | boss move drawn from the LFSR (one cycle)
// S_SHOW_BOSS    | boss move on screen
// S_BATTLE_OVER  | result held until battle_bit drops
module battle_turn_sequencer #(
  parameter int HP_W        = 8,
  parameter int USER_MAX_HP = 100,
  parameter int BOSS_MAX_HP = 120,
  parameter int SHOW_FRAMES = 60
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            battle_bit,
  input  logic            frame_tick,
  input  logic            key_valid,
  input  logic [1:0]      key_move,
  output logic            key_ready,
  output logic [HP_W-1:0] user_hp,
  output logic [HP_W-1:0] boss_hp,
  output logic [2:0]      phase,
  output logic            show_valid,
  output logic [1:0]      show_move,
  output logic            show_is_boss,
  output logic            battle_done,
  output logic            user_won
);

  typedef enum logic [2:0] {
    S_NO_BATTLE    = 3'd0,
    S_INIT_BOSS    = 3'd1,
    S_START_BATTLE = 3'd2,
    S_USER_TURN    = 3'd3,
    S_SHOW_USER    = 3'd4,
    S_BOSS_TURN    = 3'd5,
    S_SHOW_BOSS    = 3'd6,
    S_BATTLE_OVER  = 3'd7
  } state_t;

  localparam int CNT_W = $clog2(SHOW_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHOW_FRAMES - 1);

  localparam logic [HP_W-1:0] USER_MAX   = HP_W'(USER_MAX_HP);
  localparam logic [HP_W-1:0] BOSS_MAX   = HP_W'(BOSS_MAX_HP);
  localparam logic [HP_W-1:0] DMG_TACKLE = HP_W'(10);
  localparam logic [HP_W-1:0] DMG_EMBER  = HP_W'(15);
  localparam logic [HP_W-1:0] DMG_BLAST  = HP_W'(20);
  localparam logic [HP_W-1:0] HEAL_USER  = HP_W'(12);
  localparam logic [HP_W-1:0] BOSS_DMG0  = HP_W'(8);
  localparam logic [HP_W-1:0] BOSS_DMG1  = HP_W'(12);
  localparam logic [HP_W-1:0] BOSS_DMG2  = HP_W'(16);
  localparam logic [HP_W-1:0] HEAL_BOSS  = HP_W'(10);

  state_t            r_state;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [7:0]        r_lfsr;
  logic [HP_W-1:0]   r_user_hp;
  logic [HP_W-1:0]   r_boss_hp;
  logic              r_key_ready;
  logic              r_show_valid;
  logic [1:0]        r_show_move;
  logic              r_show_is_boss;
  logic              r_battle_done;
  logic              r_user_won;

  state_t            w_state_nxt;
  logic              w_abort;
  logic              w_counting;
  logic              w_last_tick;
  logic              w_lfsr_fb;
  logic [1:0]        w_boss_move;
  logic [HP_W-1:0]   w_user_hp_pm;
  logic [HP_W-1:0]   w_boss_hp_pm;
  logic [HP_W-1:0]   w_user_hp_bm;
  logic [HP_W-1:0]   w_boss_hp_bm;

  // One extra bit catches the borrow / carry before clamping.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                               input logic [HP_W-1:0] amt);
    logic [HP_W:0] t;
    t = {1'b0, hp} - {1'b0, amt};
    return t[HP_W] ? '0 : t[HP_W-1:0];
  endfunction

  function automatic logic [HP_W-1:0] sat_add(input logic [HP_W-1:0] hp,
                                               input logic [HP_W-1:0] amt,
                                               input logic [HP_W-1:0] max_hp);
    logic [HP_W:0] t;
    t = {1'b0, hp} + {1'b0, amt};
    return (t > {1'b0, max_hp}) ? max_hp : t[HP_W-1:0];
  endfunction

  assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_boss_move = r_lfsr[1:0];
  assign w_abort     = !battle_bit && (r_state != S_NO_BATTLE) && (r_state != S_BATTLE_OVER);
  assign w_counting  = (r_state == S_START_BATTLE) || (r_state == S_SHOW_USER) ||
                       (r_state == S_SHOW_BOSS);
  assign w_last_tick = frame_tick && (r_frame_cnt == CNT_LAST);

  always_comb begin
    w_user_hp_pm = r_user_hp;
    w_boss_hp_pm = r_boss_hp;
    case (key_move)
      2'd0:    w_boss_hp_pm = sat_sub(r_boss_hp, DMG_TACKLE);
      2'd1:    w_boss_hp_pm = sat_sub(r_boss_hp, DMG_EMBER);
      2'd2:    w_boss_hp_pm = sat_sub(r_boss_hp, DMG_BLAST);
      default: w_user_hp_pm = sat_add(r_user_hp, HEAL_USER, USER_MAX);
    endcase
    w_user_hp_bm = r_user_hp;
    w_boss_hp_bm = r_boss_hp;
    case (w_boss_move)
      2'd0:    w_user_hp_bm = sat_sub(r_user_hp, BOSS_DMG0);
      2'd1:    w_user_hp_bm = sat_sub(r_user_hp, BOSS_DMG1);
      2'd2:    w_user_hp_bm = sat_sub(r_user_hp, BOSS_DMG2);
      default: w_boss_hp_bm = sat_add(r_boss_hp, HEAL_BOSS, BOSS_MAX);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_NO_BATTLE:    if (battle_bit) w_state_nxt = S_INIT_BOSS;
      S_INIT_BOSS:    w_state_nxt = S_START_BATTLE;
      S_START_BATTLE: if (w_last_tick) w_state_nxt = S_USER_TURN;
      S_USER_TURN:    if (key_valid && r_key_ready) w_state_nxt = S_SHOW_USER;
      S_SHOW_USER:    if (w_last_tick)
                        w_state_nxt = (r_boss_hp == '0) ? S_BATTLE_OVER : S_BOSS_TURN;
      S_BOSS_TURN:    w_state_nxt = S_SHOW_BOSS;
      S_SHOW_BOSS:    if (w_last_tick)
                        w_state_nxt = (r_user_hp == '0) ? S_BATTLE_OVER : S_USER_TURN;
      S_BATTLE_OVER:  if (!battle_bit) w_state_nxt = S_NO_BATTLE;
      default:        w_state_nxt = S_NO_BATTLE;
    endcase
    // Leaving the battle takes priority over any tick or handshake.
    if (w_abort) w_state_nxt = S_NO_BATTLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_NO_BATTLE;
      r_frame_cnt    <= '0;
      r_lfsr         <= 8'hA5;
      r_user_hp      <= '0;
      r_boss_hp      <= '0;
      r_key_ready    <= 1'b0;
      r_show_valid   <= 1'b0;
      r_show_move    <= 2'd0;
      r_show_is_boss <= 1'b0;
      r_battle_done  <= 1'b0;
      r_user_won     <= 1'b0;
    end else begin
      r_lfsr        <= {r_lfsr[6:0], w_lfsr_fb};
      r_state       <= w_state_nxt;
      r_key_ready   <= (w_state_nxt == S_USER_TURN);
      r_show_valid  <= (w_state_nxt == S_SHOW_USER) || (w_state_nxt == S_SHOW_BOSS);
      r_battle_done <= (w_state_nxt == S_BATTLE_OVER);

      // Any state change restarts the count, so an entry-cycle tick is dropped.
      if (w_state_nxt != r_state)
        r_frame_cnt <= '0;
      else if (w_counting && frame_tick)
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);

      case (r_state)
        S_INIT_BOSS: begin
          r_user_hp  <= USER_MAX;
          r_boss_hp  <= BOSS_MAX;
          r_user_won <= 1'b0;
        end
        S_USER_TURN: if (w_state_nxt == S_SHOW_USER) begin
          r_user_hp      <= w_user_hp_pm;
          r_boss_hp      <= w_boss_hp_pm;
          r_show_move    <= key_move;
          r_show_is_boss <= 1'b0;
        end
        S_SHOW_USER: if (w_state_nxt == S_BATTLE_OVER) r_user_won <= 1'b1;
        S_BOSS_TURN: if (w_state_nxt == S_SHOW_BOSS) begin
          r_user_hp      <= w_user_hp_bm;
          r_boss_hp      <= w_boss_hp_bm;
          r_show_move    <= w_boss_move;
          r_show_is_boss <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign key_ready    = r_key_ready;
  assign user_hp      = r_user_hp;
  assign boss_hp      = r_boss_hp;
  assign phase        = r_state;
  assign show_valid   = r_show_valid;
  assign show_move    = r_show_move;
  assign show_is_boss = r_show_is_boss;
  assign battle_done  = r_battle_done;
  assign user_won     = r_user_won;

endmodule

// File: doc/battle_turn_sequencer.md
Name: battle_turn_sequencer

Overview:
Turn-based battle controller that sequences one player-vs-boss encounter once the overworld raises battle_bit. It owns both HP registers and accepts the player's move through a valid/ready handshake from the keyboard decoder. It picks the boss move from an internal LFSR, applies damage and heal arithmetic, and holds each move on screen for a fixed number of video frames. Outputs drive the battle sprite/text renderer and the return-to-overworld logic.

Parameters:
HP_W, 8, width of HP registers
USER_MAX_HP, 100, player HP loaded at battle start
BOSS_MAX_HP, 120, boss HP loaded at battle start
SHOW_FRAMES, 60, frame_tick pulses each display phase lasts (intro and each move)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
battle_bit  in  1  level; 1 = overworld has entered a battle
frame_tick  in  1  one-cycle pulse per vsync
key_valid  in  1  player move offered
key_move  in  2  0=TACKLE, 1=EMBER, 2=BLAST, 3=HEAL
key_ready  out  1  high only in USER_TURN
user_hp  out  HP_W  player HP
boss_hp  out  HP_W  boss HP
phase  out  3  current state encoding, listed order 0..7
show_valid  out  1  high in SHOW_USER_MOVE / SHOW_BOSS_MOVE
show_move  out  2  move being displayed
show_is_boss  out  1  1 when the displayed move is the boss's
battle_done  out  1  high in BATTLE_OVER
user_won  out  1  valid while battle_done

Behaviour:
- Reset: state NO_BATTLE. user_hp=0, boss_hp=0, all 1-bit outputs 0, show_move=0, frame counter 0, LFSR=8'hA5.
- States: NO_BATTLE(0), INIT_BOSS(1), START_BATTLE(2), USER_TURN(3), SHOW_USER_MOVE(4), BOSS_TURN(5), SHOW_BOSS_MOVE(6), BATTLE_OVER(7).
- NO_BATTLE: on battle_bit=1, go to INIT_BOSS.
- INIT_BOSS: lasts exactly 1 cycle. Loads user_hp=USER_MAX_HP, boss_hp=BOSS_MAX_HP, clears the frame counter and user_won. Then START_BATTLE.
- START_BATTLE: counts frame_tick. On the tick that makes the count SHOW_FRAMES, go to USER_TURN and clear the counter.
- USER_TURN: key_ready=1. A handshake (key_valid & key_ready) is taken in one cycle. Next cycle: boss_hp/user_hp updated, show_move=key_move, show_is_boss=0, state SHOW_USER_MOVE. No update without the handshake.
- Player move table: 0 → boss −10; 1 → boss −15; 2 → boss −20; 3 → user +12.
- SHOW_USER_MOVE: waits SHOW_FRAMES ticks. Then boss_hp==0 → BATTLE_OVER with user_won=1; otherwise BOSS_TURN.
- BOSS_TURN: lasts 1 cycle. Move = LFSR[1:0] sampled this cycle. Next cycle: HP updated, show_move=move, show_is_boss=1, state SHOW_BOSS_MOVE.
- Boss move table: 0 → user −8; 1 → user −12; 2 → user −16; 3 → boss +10.
- SHOW_BOSS_MOVE: waits SHOW_FRAMES ticks. Then user_hp==0 → BATTLE_OVER with user_won=0; otherwise USER_TURN.
- Arithmetic: damage saturates at 0 (no wrap). Heal saturates at the respective MAX_HP. Computed at HP_W+1 bits, then clamped.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Shifts every clk, including outside battle. Never reaches 0.
- BATTLE_OVER: holds HP and user_won. When battle_bit=0, go to NO_BATTLE.
- battle_bit falling in any state 1–6: next state NO_BATTLE. show_valid and key_ready drop the same cycle; HP values hold until the next INIT_BOSS.
- battle_bit and frame_tick in the same cycle: the abort wins.
- frame_tick coinciding with a state entry does not count in the new state.
- key_valid outside USER_TURN is ignored and not buffered.
- Reset mid-battle returns every output to its reset value on the next edge.

Test Plan:
- Reset, raise battle_bit → INIT_BOSS for 1 cycle, then user_hp=100, boss_hp=120; USER_TURN only after 60 frame_ticks (phase=3).
- USER_TURN, key_move=2 with handshake → boss_hp=100, show_move=2, show_is_boss=0; after 60 ticks, BOSS_TURN lasts 1 cycle with show_is_boss=1.
- Force boss_hp=15, player move 1 → boss_hp=0 (no wrap); after 60 ticks, battle_done=1, user_won=1; drop battle_bit → phase=0.
- user_hp=95 then player HEAL → user_hp=100 (clamped). Boss heal at boss_hp=115 → 120.
- user_hp=5, boss deals 8 → user_hp=0; after the show phase, battle_done=1, user_won=0.
- Drop battle_bit during SHOW_USER_MOVE → phase=0 next cycle, show_valid=0. key_valid pulses in NO_BATTLE leave HP unchanged.
